register_bank_2r1w: RTL and testbench

//  Parametrised multi-register bank; generalises the single flip-flop register
//  to NrOfRegs words with two asynchronous read ports and one write port.

---
 rtl/register_bank_2r1w_if.sv | 28 ++
 rtl/register_bank_2r1w.sv | 72 +++++++
 tb/tb_register_bank_2r1w.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_bank_2r1w_if.sv
// Register-bank access bundle: write qualifiers, write port, two read ports, tri-state select.
// The master drives the controls and addresses. The slave is the bank and returns the read data.
interface register_bank_2r1w_if #(
  parameter int NrOfBits = 32,
  parameter int AddrBits = 5
);
  logic                ClockEnable;
  logic                Tick;
  logic                cs;
  logic                pre;
  logic                WE;
  logic [AddrBits-1:0] WAddr;
  logic [NrOfBits-1:0] WData;
  logic [AddrBits-1:0] RAddr1;
  logic [AddrBits-1:0] RAddr2;
  logic [NrOfBits-1:0] RData1;
  logic [NrOfBits-1:0] RData2;

  modport master (
    output ClockEnable, Tick, cs, pre, WE, WAddr, WData, RAddr1, RAddr2,
    input  RData1, RData2
  );

  modport slave (
    input  ClockEnable, Tick, cs, pre, WE, WAddr, WData, RAddr1, RAddr2,
    output RData1, RData2
  );
endinterface

// File: rtl/register_bank_2r1w.sv
// Bank of NrOfRegs registers with one write port and two zero-latency read ports.
// Supports async reset and preset, a hardwired x0, optional write bypass and a selectable clock edge.
module register_bank_2r1w #(
  parameter int NrOfBits    = 32,
  parameter int NrOfRegs    = 32,
  parameter int AddrBits    = 5,
  parameter bit ActiveLevel = 1'b1,
  parameter bit ZeroReg     = 1'b1,
  parameter bit Bypass      = 1'b0
) (
  input logic                  Clock,
  input logic                  Reset,
  register_bank_2r1w_if.slave  bus
);

  logic [NrOfBits-1:0] regs [NrOfRegs];
  logic [NrOfBits-1:0] rd1;
  logic [NrOfBits-1:0] rd2;
  logic                wr_commit;

  // An address is live when it maps to a real, writable register.
  function automatic logic addr_live(input logic [AddrBits-1:0] a);
    return (int'(a) < NrOfRegs) && !(ZeroReg && (a == '0));
  endfunction

  // An asserted Reset or pre wins at the edge, so neither can let a write commit or bypass.
  assign wr_commit = bus.WE && bus.ClockEnable && bus.Tick && !Reset && !bus.pre
                     && addr_live(bus.WAddr);

  for (genvar i = 0; i < NrOfRegs; i++) begin : g_reg
    if (ZeroReg && (i == 0)) begin : g_zero
      assign regs[i] = '0;
    end else begin : g_ff
      logic [NrOfBits-1:0] q;
      logic                we_i;

      assign we_i    = wr_commit && (int'(bus.WAddr) == i);
      assign regs[i] = q;

      // NOTE: every word sits on its own async clear/preset, so Reset and pre take
      // effect immediately. This is a flop array, not an inferable RAM.
      if (ActiveLevel) begin : g_rise
        always_ff @(posedge Clock or posedge Reset or posedge bus.pre) begin
          // NOTE: state updates use <= so every register samples pre-edge values.
          if (Reset)      q <= '0;
          else if (bus.pre) q <= '1;
          else if (we_i)  q <= bus.WData;
        end
      end else begin : g_fall
        always_ff @(negedge Clock or posedge Reset or posedge bus.pre) begin
          if (Reset)        q <= '0;
          else if (bus.pre) q <= '1;
          else if (we_i)    q <= bus.WData;
        end
      end
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the block can infer a latch.
    rd1 = '0;
    rd2 = '0;
    if (Bypass && wr_commit && (bus.RAddr1 == bus.WAddr)) rd1 = bus.WData;
    else if (addr_live(bus.RAddr1))                       rd1 = regs[bus.RAddr1];
    if (Bypass && wr_commit && (bus.RAddr2 == bus.WAddr)) rd2 = bus.WData;
    else if (addr_live(bus.RAddr2))                       rd2 = regs[bus.RAddr2];
  end

  assign bus.RData1 = bus.cs ? {NrOfBits{1'bz}} : rd1;
  assign bus.RData2 = bus.cs ? {NrOfBits{1'bz}} : rd2;

endmodule

// File: tb/tb_register_bank_2r1w.sv
// Scoreboard bench for register_bank_2r1w: default bank, a 24-word bypass bank and a falling-edge bank.
// Expected read values are queued when the read is set up and popped when the output is sampled.
module tb_register_bank_2r1w;
  localparam int W = 32;
  localparam int A = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_v;
  logic [W-1:0] zval = 'z;
  logic [W-1:0] model_a [32];
  logic [W-1:0] model_b [32];

  register_bank_2r1w_if #(.NrOfBits(W), .AddrBits(A)) bus_a ();
  register_bank_2r1w_if #(.NrOfBits(W), .AddrBits(A)) bus_b ();
  register_bank_2r1w_if #(.NrOfBits(W), .AddrBits(A)) bus_c ();

  register_bank_2r1w u_a (.Clock(clk), .Reset(rst), .bus(bus_a));
  register_bank_2r1w #(.NrOfRegs(24), .Bypass(1'b1)) u_b (.Clock(clk), .Reset(rst), .bus(bus_b));
  register_bank_2r1w #(.ActiveLevel(1'b0)) u_c (.Clock(clk), .Reset(rst), .bus(bus_c));

  always #5 clk = ~clk;

  task automatic idle_all();
    bus_a.ClockEnable = 1'b1; bus_a.Tick = 1'b1; bus_a.cs = 1'b0; bus_a.pre = 1'b0;
    bus_a.WE = 1'b0; bus_a.WAddr = '0; bus_a.WData = '0; bus_a.RAddr1 = '0; bus_a.RAddr2 = '0;
    bus_b.ClockEnable = 1'b1; bus_b.Tick = 1'b1; bus_b.cs = 1'b0; bus_b.pre = 1'b0;
    bus_b.WE = 1'b0; bus_b.WAddr = '0; bus_b.WData = '0; bus_b.RAddr1 = '0; bus_b.RAddr2 = '0;
    bus_c.ClockEnable = 1'b1; bus_c.Tick = 1'b1; bus_c.cs = 1'b0; bus_c.pre = 1'b0;
    bus_c.WE = 1'b0; bus_c.WAddr = '0; bus_c.WData = '0; bus_c.RAddr1 = '0; bus_c.RAddr2 = '0;
  endtask

  // Inputs change 2 time units after a rising edge, well clear of both edges.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      bus_a.RAddr1 = A'(i);
      bus_a.RAddr2 = A'(31 - i);
      exp_q.push_back(model_a[i]);
      exp_q.push_back(model_a[31 - i]);
      #1;
      total++; exp_v = exp_q.pop_front();
      if (bus_a.RData1 !== exp_v) begin
        bad++; $display("FAIL reset_rd1 addr=%0d got=%h exp=%h", i, bus_a.RData1, exp_v);
      end
      total++; exp_v = exp_q.pop_front();
      if (bus_a.RData2 !== exp_v) begin
        bad++; $display("FAIL reset_rd2 addr=%0d got=%h exp=%h", 31 - i, bus_a.RData2, exp_v);
      end
    end
  endtask

  task automatic test_write();
    logic [2:0] quals [3] = '{3'b011, 3'b101, 3'b110};
    step();
    bus_a.WE = 1'b1; bus_a.WAddr = 5'd5; bus_a.WData = 32'hDEADBEEF;
    bus_a.RAddr1 = 5'd5; bus_a.RAddr2 = 5'd5;
    exp_q.push_back(model_a[5]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData1 !== exp_v) begin
      bad++; $display("FAIL write_before_edge got=%h exp=%h", bus_a.RData1, exp_v);
    end
    model_a[5] = 32'hDEADBEEF;
    step();
    bus_a.WE = 1'b0;
    exp_q.push_back(model_a[5]);
    exp_q.push_back(model_a[5]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData1 !== exp_v) begin
      bad++; $display("FAIL write_rd1 got=%h exp=%h", bus_a.RData1, exp_v);
    end
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData2 !== exp_v) begin
      bad++; $display("FAIL write_rd2 got=%h exp=%h", bus_a.RData2, exp_v);
    end
    // Drop one of WE / ClockEnable / Tick at a time; no write may land.
    for (int k = 0; k < 3; k++) begin
      {bus_a.WE, bus_a.ClockEnable, bus_a.Tick} = quals[k];
      bus_a.WData = 32'h11111111;
      step();
      bus_a.WE = 1'b0; bus_a.ClockEnable = 1'b1; bus_a.Tick = 1'b1;
      exp_q.push_back(model_a[5]);
      #1;
      total++; exp_v = exp_q.pop_front();
      if (bus_a.RData1 !== exp_v) begin
        bad++; $display("FAIL write_qual%0d got=%h exp=%h", k, bus_a.RData1, exp_v);
      end
    end
  endtask

  task automatic test_zero_pre();
    step();
    bus_a.WE = 1'b1; bus_a.WAddr = 5'd0; bus_a.WData = 32'h12345678;
    step();
    bus_a.WE = 1'b0; bus_a.RAddr1 = 5'd0; bus_a.RAddr2 = 5'd0;
    exp_q.push_back(32'h0);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData1 !== exp_v) begin
      bad++; $display("FAIL zero_reg_write got=%h exp=%h", bus_a.RData1, exp_v);
    end
    bus_a.pre = 1'b1;
    #1 bus_a.pre = 1'b0;
    for (int i = 1; i < 32; i++) model_a[i] = '1;
    bus_a.RAddr1 = 5'd0; bus_a.RAddr2 = 5'd31;
    exp_q.push_back(model_a[0]);
    exp_q.push_back(model_a[31]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData1 !== exp_v) begin
      bad++; $display("FAIL pre_reg0 got=%h exp=%h", bus_a.RData1, exp_v);
    end
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData2 !== exp_v) begin
      bad++; $display("FAIL pre_reg31 got=%h exp=%h", bus_a.RData2, exp_v);
    end
    bus_a.RAddr1 = 5'd5;
    exp_q.push_back(model_a[5]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData1 !== exp_v) begin
      bad++; $display("FAIL pre_reg5 got=%h exp=%h", bus_a.RData1, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    int r1;
    int r2;
    step();
    bus_a.WE = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus_a.WAddr = A'(i);
      bus_a.WData = $urandom;
      if (i != 0) model_a[i] = bus_a.WData;
      step();
    end
    bus_a.WE = 1'b0;
    for (int j = 0; j < 16; j++) begin
      r1 = $urandom_range(0, 31);
      r2 = (j % 2 == 0) ? r1 : $urandom_range(0, 31);
      bus_a.RAddr1 = A'(r1);
      bus_a.RAddr2 = A'(r2);
      exp_q.push_back(model_a[r1]);
      exp_q.push_back(model_a[r2]);
      #1;
      total++; exp_v = exp_q.pop_front();
      if (bus_a.RData1 !== exp_v) begin
        bad++; $display("FAIL b2b_rd1 addr=%0d got=%h exp=%h", r1, bus_a.RData1, exp_v);
      end
      total++; exp_v = exp_q.pop_front();
      if (bus_a.RData2 !== exp_v) begin
        bad++; $display("FAIL b2b_rd2 addr=%0d got=%h exp=%h", r2, bus_a.RData2, exp_v);
      end
    end
  endtask

  task automatic test_bypass();
    // Bank without bypass: old value before the edge, new value after it.
    step();
    bus_a.WE = 1'b1; bus_a.WAddr = 5'd7; bus_a.WData = 32'hA5A5A5A5; bus_a.RAddr2 = 5'd7;
    exp_q.push_back(model_a[7]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData2 !== exp_v) begin
      bad++; $display("FAIL nobypass_old got=%h exp=%h", bus_a.RData2, exp_v);
    end
    model_a[7] = 32'hA5A5A5A5;
    step();
    bus_a.WE = 1'b0;
    exp_q.push_back(model_a[7]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData2 !== exp_v) begin
      bad++; $display("FAIL nobypass_new got=%h exp=%h", bus_a.RData2, exp_v);
    end
    // Bypass bank, 24 registers.
    bus_b.WE = 1'b1; bus_b.WAddr = 5'd7; bus_b.WData = 32'h11112222;
    step();
    model_b[7] = 32'h11112222;
    bus_b.WData = 32'hA5A5A5A5; bus_b.RAddr2 = 5'd7; bus_b.RAddr1 = 5'd8;
    exp_q.push_back(32'hA5A5A5A5);
    exp_q.push_back(model_b[8]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData2 !== exp_v) begin
      bad++; $display("FAIL bypass_rd2 got=%h exp=%h", bus_b.RData2, exp_v);
    end
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData1 !== exp_v) begin
      bad++; $display("FAIL bypass_other got=%h exp=%h", bus_b.RData1, exp_v);
    end
    bus_b.Tick = 1'b0;
    exp_q.push_back(model_b[7]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData2 !== exp_v) begin
      bad++; $display("FAIL bypass_no_tick got=%h exp=%h", bus_b.RData2, exp_v);
    end
    bus_b.Tick = 1'b1;
    step();
    model_b[7] = 32'hA5A5A5A5;
    bus_b.WE = 1'b0;
    exp_q.push_back(model_b[7]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData2 !== exp_v) begin
      bad++; $display("FAIL bypass_after got=%h exp=%h", bus_b.RData2, exp_v);
    end
    // Last valid register bypasses; out-of-range and reg 0 never do.
    bus_b.WE = 1'b1; bus_b.WAddr = 5'd23; bus_b.WData = 32'h0BADF00D; bus_b.RAddr1 = 5'd23;
    exp_q.push_back(32'h0BADF00D);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData1 !== exp_v) begin
      bad++; $display("FAIL bypass_top got=%h exp=%h", bus_b.RData1, exp_v);
    end
    step();
    model_b[23] = 32'h0BADF00D;
    bus_b.WAddr = 5'd30; bus_b.WData = 32'hFFFF0000; bus_b.RAddr1 = 5'd30; bus_b.RAddr2 = 5'd23;
    exp_q.push_back(32'h0);
    exp_q.push_back(model_b[23]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData1 !== exp_v) begin
      bad++; $display("FAIL bypass_oor got=%h exp=%h", bus_b.RData1, exp_v);
    end
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData2 !== exp_v) begin
      bad++; $display("FAIL write_top got=%h exp=%h", bus_b.RData2, exp_v);
    end
    step();
    bus_b.WAddr = 5'd0; bus_b.WData = 32'h13572468; bus_b.RAddr2 = 5'd0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData1 !== exp_v) begin
      bad++; $display("FAIL oor_after got=%h exp=%h", bus_b.RData1, exp_v);
    end
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData2 !== exp_v) begin
      bad++; $display("FAIL bypass_reg0 got=%h exp=%h", bus_b.RData2, exp_v);
    end
    step();
    bus_b.WE = 1'b0;
  endtask

  task automatic test_falling_edge();
    @(negedge clk);
    #1;
    bus_c.WE = 1'b1; bus_c.WAddr = 5'd3; bus_c.WData = 32'h1; bus_c.RAddr1 = 5'd3;
    exp_q.push_back(32'h0);
    @(posedge clk);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_c.RData1 !== exp_v) begin
      bad++; $display("FAIL negedge_rise got=%h exp=%h", bus_c.RData1, exp_v);
    end
    exp_q.push_back(32'h1);
    @(negedge clk);
    #1;
    bus_c.WE = 1'b0;
    total++; exp_v = exp_q.pop_front();
    if (bus_c.RData1 !== exp_v) begin
      bad++; $display("FAIL negedge_fall got=%h exp=%h", bus_c.RData1, exp_v);
    end
  endtask

  task automatic test_cs();
    step();
    bus_a.cs = 1'b1; bus_a.RAddr1 = 5'd5; bus_a.RAddr2 = 5'd31;
    bus_a.WE = 1'b1; bus_a.WAddr = 5'd9; bus_a.WData = 32'h99990009;
    exp_q.push_back(zval);
    exp_q.push_back(zval);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData1 !== exp_v) begin
      bad++; $display("FAIL cs_rd1 got=%h exp=%h", bus_a.RData1, exp_v);
    end
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData2 !== exp_v) begin
      bad++; $display("FAIL cs_rd2 got=%h exp=%h", bus_a.RData2, exp_v);
    end
    model_a[9] = 32'h99990009;
    step();
    bus_a.WE = 1'b0; bus_a.cs = 1'b0; bus_a.RAddr1 = 5'd9;
    exp_q.push_back(model_a[9]);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_a.RData1 !== exp_v) begin
      bad++; $display("FAIL cs_write got=%h exp=%h", bus_a.RData1, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    step();
    bus_a.WE = 1'b1; bus_a.WAddr = 5'd10; bus_a.WData = 32'hCAFEF00D;
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_a.WE = 1'b0;
    for (int i = 0; i < 32; i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      bus_a.RAddr1 = A'(i);
      bus_a.RAddr2 = A'(31 - i);
      exp_q.push_back(model_a[i]);
      exp_q.push_back(model_a[31 - i]);
      #1;
      total++; exp_v = exp_q.pop_front();
      if (bus_a.RData1 !== exp_v) begin
        bad++; $display("FAIL rstmid_rd1 addr=%0d got=%h exp=%h", i, bus_a.RData1, exp_v);
      end
      total++; exp_v = exp_q.pop_front();
      if (bus_a.RData2 !== exp_v) begin
        bad++; $display("FAIL rstmid_rd2 addr=%0d got=%h exp=%h", 31 - i, bus_a.RData2, exp_v);
      end
    end
    bus_b.RAddr1 = 5'd7; bus_c.RAddr1 = 5'd3;
    exp_q.push_back(model_b[7]);
    exp_q.push_back(32'h0);
    #1;
    total++; exp_v = exp_q.pop_front();
    if (bus_b.RData1 !== exp_v) begin
      bad++; $display("FAIL rstmid_bank_b got=%h exp=%h", bus_b.RData1, exp_v);
    end
    total++; exp_v = exp_q.pop_front();
    if (bus_c.RData1 !== exp_v) begin
      bad++; $display("FAIL rstmid_bank_c got=%h exp=%h", bus_c.RData1, exp_v);
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_write();
    test_zero_pre();
    test_back_to_back();
    test_bypass();
    test_falling_edge();
    test_cs();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
